// File: rtl/div_tick_pkg.sv
// Shared types and constants for the divider tap selector.
package div_tick_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_OLD = 2'd1,
      WAIT_NEW = 2'd2,
      ACK      = 2'd3
   } sel_state_t;

   localparam int N_DIV_MAX = 256;
   localparam int ACK_HOLD  = 1;

   function automatic int div_clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/div_tick_edge.sv
// Registers the selected divider level behind the switch gate and flags its rising edge.
module div_tick_edge #(
   parameter int N_DIV = 8,
   parameter int SEL_W = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N_DIV-1:0] i_div_in,
   input  logic [SEL_W-1:0] i_sel,
   input  logic             i_gate,
   output logic             o_clk_out,
   output logic             o_tick
);

   logic w_lvl;
   logic r_clk_out;
   logic r_tick;

   assign w_lvl = i_div_in[i_sel];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         r_clk_out <= ~i_gate & w_lvl;
         r_tick    <= ~i_gate & w_lvl & ~r_clk_out;
      end
   end

   assign o_clk_out = r_clk_out;
   assign o_tick    = r_tick;

endmodule

// File: rtl/div_tick_sel.sv
// Glitch-free run-time tap selector for the power-of-two clock divider.
// Define DIV_TICK_CNT_EN to build the free-running tick counter; otherwise o_tick_cnt is 0.
//
// state    | meaning
// IDLE     | tap stable, accepting requests (after ACK_HOLD cycles)
// WAIT_OLD | waiting for the old tap to read low, then gate the output
// WAIT_NEW | gated; waiting for the new tap to read low before switching
// ACK      | switch complete; sel_ack pulses in the following cycle
module div_tick_sel
   import div_tick_pkg::*;
#(
   parameter int N_DIV   = 8,
   parameter int SEL_W   = div_clog2(N_DIV),
   parameter int RST_SEL = 0,
   parameter int CNT_W   = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N_DIV-1:0] i_div_in,
   input  logic             i_sel_req,
   input  logic [SEL_W-1:0] i_sel_idx,
   output logic             o_sel_ack,
   output logic             o_busy,
   output logic [SEL_W-1:0] o_cur_sel,
   output logic             o_clk_out,
   output logic             o_tick,
   output logic [CNT_W-1:0] o_tick_cnt
);

   sel_state_t       r_state;
   logic [SEL_W-1:0] r_cur_sel;
   logic [SEL_W-1:0] r_pend_idx;
   logic             r_gate;
   logic             r_sel_ack;
   logic             r_busy;
   logic [1:0]       r_hold;

   logic w_old_lvl;
   logic w_new_lvl;
   logic w_oob;
   logic w_same;

   assign w_old_lvl = i_div_in[r_cur_sel];
   assign w_new_lvl = i_div_in[r_pend_idx];
   // An out-of-range index is answered like a request for the current tap.
   assign w_oob     = (32'(i_sel_idx) >= 32'(N_DIV));
   assign w_same    = w_oob || (i_sel_idx == r_cur_sel);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_cur_sel  <= SEL_W'(RST_SEL);
         r_pend_idx <= SEL_W'(RST_SEL);
         r_gate     <= 1'b0;
         r_sel_ack  <= 1'b0;
         r_busy     <= 1'b0;
         r_hold     <= 2'd0;
      end else begin
         r_sel_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_hold != 2'd0) begin
                  r_hold <= r_hold - 2'd1;
               end else if (i_sel_req) begin
                  r_busy <= 1'b1;
                  if (w_same) begin
                     r_state <= ACK;
                  end else begin
                     r_pend_idx <= i_sel_idx;
                     r_state    <= WAIT_OLD;
                  end
               end
            end
            WAIT_OLD: begin
               if (!w_old_lvl) begin
                  r_gate  <= 1'b1;
                  r_state <= WAIT_NEW;
               end
            end
            WAIT_NEW: begin
               if (!w_new_lvl) begin
                  r_cur_sel <= r_pend_idx;
                  r_gate    <= 1'b0;
                  r_state   <= ACK;
               end
            end
            ACK: begin
               r_sel_ack <= 1'b1;
               r_busy    <= 1'b0;
               r_hold    <= 2'(ACK_HOLD);
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   div_tick_edge #(
      .N_DIV (N_DIV),
      .SEL_W (SEL_W)
   ) u_edge (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_div_in  (i_div_in),
      .i_sel     (r_cur_sel),
      .i_gate    (r_gate),
      .o_clk_out (o_clk_out),
      .o_tick    (o_tick)
   );

`ifdef DIV_TICK_CNT_EN
   logic [CNT_W-1:0] r_tick_cnt;
   logic             w_tick_set;

   // Counts in the same edge that raises tick, so the count already includes it.
   assign w_tick_set = ~r_gate & w_old_lvl & ~o_clk_out;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tick_cnt <= '0;
      end else if (w_tick_set) begin
         r_tick_cnt <= r_tick_cnt + CNT_W'(1);
      end
   end

   assign o_tick_cnt = r_tick_cnt;
`else
   assign o_tick_cnt = '0;
`endif

   assign o_sel_ack = r_sel_ack;
   assign o_busy    = r_busy;
   assign o_cur_sel = r_cur_sel;

endmodule
